// File: rtl/i2s_peak_meter.sv
// I2S stereo capture with windowed peak-magnitude meter, all in the clk_clk domain.
// Latency: sample_valid/peak_valid 1 cycle after the bclk_rise carrying the right LSB (+2-3 sync cycles).
// Backpressure: none; outputs are pulses plus held values, the codec stream cannot be stalled.
module i2s_peak_meter #(
  parameter int SAMPLE_BITS = 16,
  parameter int WINDOW_LOG2 = 10
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic                   i2s_bclk,
  input  logic                   i2s_lrck,
  input  logic                   i2s_adcdat,
  output logic                   sample_valid,
  output logic [SAMPLE_BITS-1:0] sample_left,
  output logic [SAMPLE_BITS-1:0] sample_right,
  output logic                   peak_valid,
  output logic [SAMPLE_BITS-2:0] peak_value,
  output logic                   frame_error
);

  localparam int CW = $clog2(SAMPLE_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_BITS - 1);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

  logic [2:0] bclk_sync_q;
  logic [2:0] lrck_sync_q;
  logic [1:0] dat_sync_q;

  // Synchronisers are plain sample pipelines; left out of reset so they
  // track the pins during reset and no spurious edge appears on release.
  always_ff @(posedge clk_clk) begin
    bclk_sync_q <= {bclk_sync_q[1:0], i2s_bclk};
    lrck_sync_q <= {lrck_sync_q[1:0], i2s_lrck};
    dat_sync_q  <= {dat_sync_q[0], i2s_adcdat};
  end

  logic bclk_rise, lr_edge, lr_lvl, dat_s;
  assign bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
  assign lr_edge   = lrck_sync_q[1] ^ lrck_sync_q[2];
  assign lr_lvl    = lrck_sync_q[1];
  assign dat_s     = dat_sync_q[1];

  state_t                 state_q, state_d;
  logic                   chan_q, chan_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic [SAMPLE_BITS-1:0] shreg_q, shreg_d;
  logic                   word_done, trunc;
  logic [SAMPLE_BITS-1:0] word;

  // Completed word includes the bit arriving on the current bclk_rise.
  assign word = {shreg_q[SAMPLE_BITS-2:0], dat_s};

  // FSM state register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= IDLE;
      chan_q   <= 1'b0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
    end
  end

  // FSM next state: an LR edge always wins; a coincident bclk_rise is the delay bit.
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    trunc     = 1'b0;
    if (lr_edge) begin
      chan_d   = lr_lvl;
      bitcnt_d = '0;
      trunc    = (state_q == SKIP) || (state_q == SHIFT);
      state_d  = bclk_rise ? SHIFT : SKIP;
    end else if (bclk_rise) begin
      case (state_q)
        SKIP: begin
          state_d  = SHIFT;
          bitcnt_d = '0;
        end
        SHIFT: begin
          shreg_d  = word;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == LAST_BIT) begin
            state_d   = HOLD;
            word_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Magnitude with the most negative code saturated to full scale.
  function automatic logic [SAMPLE_BITS-2:0] mag(input logic [SAMPLE_BITS-1:0] s);
    logic [SAMPLE_BITS-1:0] n;
    n = -s;
    if (!s[SAMPLE_BITS-1])             mag = s[SAMPLE_BITS-2:0];
    else if (s[SAMPLE_BITS-2:0] == '0) mag = '1;
    else                               mag = n[SAMPLE_BITS-2:0];
  endfunction

  logic [SAMPLE_BITS-1:0] left_hold_q, left_hold_d;
  logic                   left_ok_q, left_ok_d;
  logic                   sv_q, sv_d;
  logic [SAMPLE_BITS-1:0] sl_q, sl_d, sr_q, sr_d;
  logic                   pv_q, pv_d;
  logic [SAMPLE_BITS-2:0] pk_q, pk_d, acc_q, acc_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic                   fe_q, fe_d;
  logic [SAMPLE_BITS-2:0] mag_l, mag_r, m_frame, m_max;

  assign mag_l   = mag(left_hold_q);
  assign mag_r   = mag(word);
  assign m_frame = (mag_l > mag_r) ? mag_l : mag_r;
  assign m_max   = (acc_q > m_frame) ? acc_q : m_frame;

  // Frame assembly and peak window registers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      sv_q        <= 1'b0;
      sl_q        <= '0;
      sr_q        <= '0;
      pv_q        <= 1'b0;
      pk_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      fe_q        <= 1'b0;
    end else begin
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      sv_q        <= sv_d;
      sl_q        <= sl_d;
      sr_q        <= sr_d;
      pv_q        <= pv_d;
      pk_q        <= pk_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      fe_q        <= fe_d;
    end
  end

  // A right word only forms a frame when a good left word precedes it;
  // the last frame of a window publishes the peak and restarts the accumulator.
  always_comb begin
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    sv_d        = 1'b0;
    sl_d        = sl_q;
    sr_d        = sr_q;
    pv_d        = 1'b0;
    pk_d        = pk_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    fe_d        = trunc;
    if (trunc) left_ok_d = 1'b0;
    if (word_done) begin
      if (!chan_q) begin
        left_hold_d = word;
        left_ok_d   = 1'b1;
      end else if (left_ok_q) begin
        sv_d      = 1'b1;
        sl_d      = left_hold_q;
        sr_d      = word;
        left_ok_d = 1'b0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          pv_d  = 1'b1;
          pk_d  = m_max;
          acc_d = '0;
        end else begin
          acc_d = m_max;
        end
      end
    end
  end

  assign sample_valid = sv_q;
  assign sample_left  = sl_q;
  assign sample_right = sr_q;
  assign peak_valid   = pv_q;
  assign peak_value   = pk_q;
  assign frame_error  = fe_q;

endmodule

// File: tb/tb_i2s_peak_meter.sv
// Directed bench for i2s_peak_meter driving an I2S source aligned to clk_clk.
// Latency: pulses are counted by a monitor; checks run after each half-frame.
// Backpressure: none; stimulus is free-running like the codec.
module tb_i2s_peak_meter;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        i2s_bclk, i2s_lrck, i2s_adcdat;
  logic        sample_valid, peak_valid, frame_error;
  logic [15:0] sample_left, sample_right;
  logic [14:0] peak_value;

  int checks = 0;
  int errors = 0;
  int sv_cnt = 0, pv_cnt = 0, fe_cnt = 0, pv_alone = 0;

  i2s_peak_meter #(.SAMPLE_BITS(16), .WINDOW_LOG2(2)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrck    (i2s_lrck),
    .i2s_adcdat  (i2s_adcdat),
    .sample_valid(sample_valid),
    .sample_left (sample_left),
    .sample_right(sample_right),
    .peak_valid  (peak_valid),
    .peak_value  (peak_value),
    .frame_error (frame_error)
  );

  always #10 clk_clk = ~clk_clk;

  // Pulse monitor: counts high cycles, so a stretched pulse shows up as extra counts.
  always @(negedge clk_clk) begin
    if (sample_valid) sv_cnt++;
    if (peak_valid) pv_cnt++;
    if (frame_error) fe_cnt++;
    if (peak_valid && !sample_valid) pv_alone++;
  end

  // One BCLK period of 16 clk_clk cycles; data and LR change on the falling edge,
  // or LR changes with the rising edge when coinc is set.
  task automatic slot(input logic lr, input logic d, input bit coinc);
    i2s_bclk   = 1'b0;
    i2s_adcdat = d;
    if (!coinc) i2s_lrck = lr;
    repeat (8) @(negedge clk_clk);
    i2s_bclk = 1'b1;
    if (coinc) i2s_lrck = lr;
    repeat (8) @(negedge clk_clk);
  endtask

  task automatic send_half(input logic lr, input logic [15:0] w, input int nslots,
                           input int ndata, input bit coinc, input int rst_slot);
    for (int i = 0; i < nslots; i++) begin
      logic d;
      d = 1'b0;
      if (i >= 1 && i <= ndata) d = w[16-i];
      if (i == rst_slot) begin
        reset_reset = 1'b1;
        @(negedge clk_clk);
        reset_reset = 1'b0;
      end
      slot(lr, d, coinc && (i == 0));
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_half(1'b0, l, 32, 16, 1'b0, -1);
    send_half(1'b1, r, 32, 16, 1'b0, -1);
  endtask

  task automatic test_reset;
    i2s_bclk = 1'b0; i2s_lrck = 1'b1; i2s_adcdat = 1'b0; reset_reset = 1'b1;
    repeat (6) @(negedge clk_clk);
    reset_reset = 1'b0;
    @(negedge clk_clk);
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sv got %b want 0", sample_valid); end
    checks++; if (sample_left !== 16'h0) begin errors++; $display("FAIL reset_left got %h want 0000", sample_left); end
    checks++; if (sample_right !== 16'h0) begin errors++; $display("FAIL reset_right got %h want 0000", sample_right); end
    checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL reset_pv got %b want 0", peak_valid); end
    checks++; if (peak_value !== 15'h0) begin errors++; $display("FAIL reset_peak got %h want 0000", peak_value); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_fe got %b want 0", frame_error); end
  endtask

  task automatic test_single_frame;
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_frame(16'h1234, 16'hFFFE);
    checks++; if (sv_cnt - sv0 !== 1) begin errors++; $display("FAIL single_sv_count got %0d want 1", sv_cnt - sv0); end
    checks++; if (sample_left !== 16'h1234) begin errors++; $display("FAIL single_left got %h want 1234", sample_left); end
    checks++; if (sample_right !== 16'hFFFE) begin errors++; $display("FAIL single_right got %h want fffe", sample_right); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL single_fe got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_truncated;
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_half(1'b0, 16'hBEEF, 10, 9, 1'b0, -1);
    send_half(1'b1, 16'h7777, 32, 16, 1'b0, -1);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL trunc_fe got %0d want 1", fe_cnt - fe0); end
    checks++; if (sv_cnt - sv0 !== 0) begin errors++; $display("FAIL trunc_no_sv got %0d want 0", sv_cnt - sv0); end
    send_frame(16'h0001, 16'h0002);
    checks++; if (sv_cnt - sv0 !== 1) begin errors++; $display("FAIL trunc_recover_sv got %0d want 1", sv_cnt - sv0); end
    checks++; if (sample_left !== 16'h0001) begin errors++; $display("FAIL trunc_left got %h want 0001", sample_left); end
    checks++; if (sample_right !== 16'h0002) begin errors++; $display("FAIL trunc_right got %h want 0002", sample_right); end
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL trunc_fe_after got %0d want 1", fe_cnt - fe0); end
  endtask

  task automatic test_right_first;
    int sv0;
    i2s_lrck = 1'b0; reset_reset = 1'b1;
    repeat (6) @(negedge clk_clk);
    reset_reset = 1'b0;
    sv0 = sv_cnt;
    send_half(1'b1, 16'h1111, 32, 16, 1'b0, -1);
    checks++; if (sv_cnt - sv0 !== 0) begin errors++; $display("FAIL rfirst_drop got %0d want 0", sv_cnt - sv0); end
    send_frame(16'h0003, 16'h0004);
    checks++; if (sv_cnt - sv0 !== 1) begin errors++; $display("FAIL rfirst_sv got %0d want 1", sv_cnt - sv0); end
    checks++; if (sample_left !== 16'h0003) begin errors++; $display("FAIL rfirst_left got %h want 0003", sample_left); end
    checks++; if (sample_right !== 16'h0004) begin errors++; $display("FAIL rfirst_right got %h want 0004", sample_right); end
  endtask

  task automatic test_reset_mid_and_window;
    int sv0, pv0;
    // One frame is already counted in the window; reset mid-SHIFT must discard it.
    send_half(1'b0, 16'h4321, 32, 16, 1'b0, 6);
    checks++; if (sample_left !== 16'h0) begin errors++; $display("FAIL mid_rst_left got %h want 0000", sample_left); end
    checks++; if (sample_right !== 16'h0) begin errors++; $display("FAIL mid_rst_right got %h want 0000", sample_right); end
    checks++; if (peak_value !== 15'h0) begin errors++; $display("FAIL mid_rst_peak got %h want 0000", peak_value); end
    checks++; if ({sample_valid, peak_valid, frame_error} !== 3'b000) begin errors++; $display("FAIL mid_rst_pulses got %b want 000", {sample_valid, peak_valid, frame_error}); end
    sv0 = sv_cnt; pv0 = pv_cnt;
    send_half(1'b1, 16'h2222, 32, 16, 1'b0, -1);
    checks++; if (sv_cnt - sv0 !== 0) begin errors++; $display("FAIL mid_rst_drop got %0d want 0", sv_cnt - sv0); end
    send_frame(16'd100, 16'hFFFB);
    send_frame(16'hFD44, 16'd3);
    send_frame(16'h0000, 16'h0000);
    checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL win_no_early got %0d want 0", pv_cnt - pv0); end
    send_frame(16'h8000, 16'd1);
    checks++; if (pv_cnt - pv0 !== 1) begin errors++; $display("FAIL win1_pv got %0d want 1", pv_cnt - pv0); end
    checks++; if (peak_value !== 15'h7FFF) begin errors++; $display("FAIL win1_peak got %h want 7fff", peak_value); end
    checks++; if (sample_left !== 16'h8000) begin errors++; $display("FAIL win1_left got %h want 8000", sample_left); end
    checks++; if (sv_cnt - sv0 !== 4) begin errors++; $display("FAIL win1_sv got %0d want 4", sv_cnt - sv0); end
    for (int k = 0; k < 3; k++) send_frame(16'd10, 16'hFFEC);
    checks++; if (peak_value !== 15'h7FFF) begin errors++; $display("FAIL win2_hold got %h want 7fff", peak_value); end
    send_frame(16'd10, 16'hFFEC);
    checks++; if (pv_cnt - pv0 !== 2) begin errors++; $display("FAIL win2_pv got %0d want 2", pv_cnt - pv0); end
    checks++; if (peak_value !== 15'd20) begin errors++; $display("FAIL win2_peak got %0d want 20", peak_value); end
    checks++; if (pv_alone !== 0) begin errors++; $display("FAIL pv_with_sv got %0d stray want 0", pv_alone); end
  endtask

  task automatic test_coincident;
    int sv0, fe0, pv0;
    sv0 = sv_cnt; fe0 = fe_cnt; pv0 = pv_cnt;
    send_half(1'b0, 16'hA5A5, 32, 16, 1'b1, -1);
    send_half(1'b1, 16'h5A5A, 32, 16, 1'b0, -1);
    checks++; if (sv_cnt - sv0 !== 1) begin errors++; $display("FAIL coinc_sv got %0d want 1", sv_cnt - sv0); end
    checks++; if (sample_left !== 16'hA5A5) begin errors++; $display("FAIL coinc_left got %h want a5a5", sample_left); end
    checks++; if (sample_right !== 16'h5A5A) begin errors++; $display("FAIL coinc_right got %h want 5a5a", sample_right); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL coinc_fe got %0d want 0", fe_cnt - fe0); end
    checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL coinc_pv got %0d want 0", pv_cnt - pv0); end
  endtask

  task automatic test_silent;
    int sv0, pv0, fe0;
    sv0 = sv_cnt; pv0 = pv_cnt; fe0 = fe_cnt;
    i2s_adcdat = 1'b1;
    repeat (400) @(negedge clk_clk);
    checks++; if ((sv_cnt - sv0) + (pv_cnt - pv0) + (fe_cnt - fe0) !== 0) begin errors++; $display("FAIL silent_pulses got %0d want 0", (sv_cnt - sv0) + (pv_cnt - pv0) + (fe_cnt - fe0)); end
    checks++; if (sample_left !== 16'hA5A5) begin errors++; $display("FAIL silent_left got %h want a5a5", sample_left); end
    checks++; if (peak_value !== 15'd20) begin errors++; $display("FAIL silent_peak got %0d want 20", peak_value); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_truncated;
    test_right_first;
    test_reset_mid_and_window;
    test_coincident;
    test_silent;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
